// File: rtl/txn_dispatcher.sv
// Request dispatcher: queues host addresses, issues each as a start pulse,
// waits for a falling ready acknowledge, and retries or errors on timeout.
module txn_dispatcher #(
  parameter int DEPTH     = 4,
  parameter int TIMEOUT   = 8,
  parameter int MAX_RETRY = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req_valid,
  input  logic [10:0]              req_addr,
  output logic                     req_ready,
  output logic                     start,
  output logic [10:0]              address_bus,
  input  logic                     ready,
  output logic                     done,
  output logic                     err,
  output logic [10:0]              err_addr,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam int RW = $clog2(MAX_RETRY + 1) + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESOLVE = 2'd3
  } state_t;

  state_t          state_r, next_state_s;
  logic [10:0]     mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic [TW-1:0]   timer_r;
  logic [RW-1:0]   retry_r;
  logic            seen_high_r;
  logic            push_s, pop_s, ack_s, timeout_s, retry_ok_s;
  logic [10:0]     head_s;
  logic            start_r, done_r, err_r;
  logic [10:0]     address_bus_r, err_addr_r;
  logic            start_s, done_s, err_s;
  logic [10:0]     address_bus_s, err_addr_s;

  assign head_s     = mem_r[rd_ptr_r];
  assign req_ready  = (count_r != CW'(DEPTH));
  assign push_s     = req_valid & req_ready;
  assign pop_s      = (state_r == RESOLVE);
  // A low ready only counts once a high has been seen in this attempt.
  assign ack_s      = (state_r == WAIT) & ~ready & seen_high_r;
  assign timeout_s  = (state_r == WAIT) & (timer_r == TW'(TIMEOUT - 1));
  assign retry_ok_s = (retry_r < RW'(MAX_RETRY));

  // FIFO storage, pointers and occupancy
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= 11'd0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= req_addr;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_r <= IDLE;
    else        state_r <= next_state_s;
  end

  // FSM next-state logic; acknowledge takes priority over timeout
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (count_r != CW'(0)) next_state_s = ISSUE;
        else                   next_state_s = IDLE;
      end
      ISSUE: next_state_s = WAIT;
      WAIT: begin
        if (ack_s)           next_state_s = RESOLVE;
        else if (timeout_s)  next_state_s = retry_ok_s ? ISSUE : RESOLVE;
        else                 next_state_s = WAIT;
      end
      RESOLVE: next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Output next-values, registered below so they line up with the state
  always_comb begin
    start_s       = (next_state_s == ISSUE);
    done_s        = ack_s;
    err_s         = timeout_s & ~ack_s & ~retry_ok_s;
    address_bus_s = address_bus_r;
    err_addr_s    = err_addr_r;
    if (start_s) address_bus_s = head_s;
    else         address_bus_s = address_bus_r;
    if (err_s)   err_addr_s = head_s;
    else         err_addr_s = err_addr_r;
  end

  // Registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      start_r       <= 1'b0;
      done_r        <= 1'b0;
      err_r         <= 1'b0;
      address_bus_r <= 11'd0;
      err_addr_r    <= 11'd0;
    end else begin
      start_r       <= start_s;
      done_r        <= done_s;
      err_r         <= err_s;
      address_bus_r <= address_bus_s;
      err_addr_r    <= err_addr_s;
    end
  end

  // Attempt timer, seen-high flag and retry counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      timer_r     <= '0;
      seen_high_r <= 1'b0;
      retry_r     <= '0;
    end else begin
      if (state_r == ISSUE) begin
        timer_r     <= '0;
        seen_high_r <= 1'b0;
      end else if (state_r == WAIT) begin
        timer_r     <= timer_r + TW'(1);
        seen_high_r <= seen_high_r | ready;
      end
      if ((state_r == IDLE) && (next_state_s == ISSUE))
        retry_r <= '0;
      else if (timeout_s && !ack_s && retry_ok_s)
        retry_r <= retry_r + RW'(1);
    end
  end

  assign start       = start_r;
  assign done        = done_r;
  assign err         = err_r;
  assign address_bus = address_bus_r;
  assign err_addr    = err_addr_r;
  assign count       = count_r;
  assign busy        = (state_r != IDLE) | (count_r != CW'(0));

endmodule

// File: tb/tb_txn_dispatcher.sv
// Randomized and directed bench for txn_dispatcher against a queue-based
// cycle reference model built from the request/attempt timing rules.
module tb_txn_dispatcher;

  localparam int DEPTH     = 4;
  localparam int TIMEOUT   = 8;
  localparam int MAX_RETRY = 2;
  localparam int CW        = $clog2(DEPTH) + 1;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic [10:0]   req_addr = 11'd0;
  logic          ready = 1'b0;
  logic          req_ready, start, done, err, busy;
  logic [10:0]   address_bus, err_addr;
  logic [CW-1:0] count;

  txn_dispatcher #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .start(start), .address_bus(address_bus), .ready(ready),
    .done(done), .err(err), .err_addr(err_addr), .busy(busy), .count(count)
  );

  always #5 clock = ~clock;

  typedef enum int {RM_LOW, RM_HIGH, RM_PULSE, RM_FINAL, RM_RAND} rmode_t;
  rmode_t rmode = RM_LOW;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // observed-event bookkeeping
  int          since = 1000;
  int          n_start, n_done, n_err, done_cyc;
  int          st_cyc [8];
  logic [10:0] st_addr [8];
  logic [10:0] eaddr_log [$];
  logic [10:0] host_q [$];

  // reference model: queue of accepted requests plus attempt position
  logic [10:0] m_q [$];
  int          m_t = -1;     // cycles since the current start, -1 when none
  int          m_tries = 0;  // starts issued for the current head
  bit          m_seen, m_res, m_acc;
  bit          e_start, e_done, e_err;
  logic [10:0] e_bus, e_eaddr;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    m_q.delete();
    m_t = -1; m_tries = 0; m_seen = 1'b0; m_res = 1'b0; m_acc = 1'b0;
    e_start = 1'b0; e_done = 1'b0; e_err = 1'b0;
    e_bus = 11'd0; e_eaddr = 11'd0;
  endfunction

  function automatic void model_edge();
    int sz;
    bit ack;
    e_start = 1'b0; e_done = 1'b0; e_err = 1'b0; m_acc = 1'b0;
    if (!reset) begin
      model_reset();
      return;
    end
    sz    = m_q.size();
    m_acc = req_valid && (sz != DEPTH);
    if (m_res) begin
      m_res = 1'b0;
      void'(m_q.pop_front());
    end else if (m_t == 0) begin
      m_t = 1;
    end else if (m_t > 0) begin
      ack = !ready && m_seen;
      if (ready) m_seen = 1'b1;
      if (ack) begin
        m_res = 1'b1; e_done = 1'b1; m_t = -1;
      end else if (m_t == TIMEOUT) begin
        if (m_tries <= MAX_RETRY) begin
          m_tries++; m_t = 0; m_seen = 1'b0; e_start = 1'b1; e_bus = m_q[0];
        end else begin
          m_res = 1'b1; e_err = 1'b1; e_eaddr = m_q[0]; m_t = -1;
        end
      end else begin
        m_t++;
      end
    end else if (sz != 0) begin
      m_t = 0; m_tries = 1; m_seen = 1'b0; e_start = 1'b1; e_bus = m_q[0];
    end
    if (m_acc) m_q.push_back(req_addr);
  endfunction

  task automatic compare_all();
    check_eq("start", start, e_start);
    check_eq("done", done, e_done);
    check_eq("err", err, e_err);
    check_eq("address_bus", address_bus, e_bus);
    check_eq("err_addr", err_addr, e_eaddr);
    check_eq("count", count, m_q.size());
    check_eq("req_ready", req_ready, m_q.size() != DEPTH);
    check_eq("busy", busy, (m_t >= 0) || m_res || (m_q.size() != 0));
  endtask

  function automatic logic next_ready();
    case (rmode)
      RM_LOW:   return 1'b0;
      RM_HIGH:  return 1'b1;
      RM_PULSE: return (since == 1) || (since == 2);
      RM_FINAL: return !((n_start == 1 + MAX_RETRY) && (since == TIMEOUT));
      RM_RAND:  return ($urandom_range(0, 3) == 0) ? ~ready : ready;
      default:  return 1'b0;
    endcase
  endfunction

  task automatic drive_host();
    req_valid = (host_q.size() != 0);
    req_addr  = (host_q.size() != 0) ? host_q[0] : 11'd0;
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    cyc++;
    compare_all();
    if (start) begin
      if (n_start < 8) begin
        st_cyc[n_start]  = cyc;
        st_addr[n_start] = address_bus;
      end
      n_start++;
      since = 0;
    end else begin
      since++;
    end
    if (done) begin n_done++; done_cyc = cyc; end
    if (err) eaddr_log.push_back(err_addr);
    if (err) n_err++;
    if (m_acc) void'(host_q.pop_front());
    drive_host();
    ready = next_ready();
  endtask

  task automatic clear_stats();
    n_start = 0; n_done = 0; n_err = 0; done_cyc = 0;
    eaddr_log.delete();
  endtask

  task automatic push_host(input logic [10:0] a);
    host_q.push_back(a);
    drive_host();
  endtask

  task automatic run_idle(input string tag, input int max);
    bit ok = 1'b0;
    for (int n = 0; n < max && !ok; n++) begin
      tick();
      if (host_q.size() == 0 && !busy) ok = 1'b1;
    end
    check_eq(tag, ok, 1'b1);
  endtask

  initial begin
    model_reset();
    clear_stats();
    repeat (3) tick();
    reset = 1'b1;
    tick();

    // single request, ready high for two cycles then low
    clear_stats(); rmode = RM_PULSE;
    push_host(11'h405);
    run_idle("single_budget", 100);
    check_eq("single_starts", n_start, 1);
    check_eq("single_addr", st_addr[0], 11'h405);
    check_eq("single_done", n_done, 1);
    check_eq("single_err", n_err, 0);
    check_eq("single_lat", done_cyc - st_cyc[0], 4);
    check_eq("single_count", count, 0);

    // stale low ready left over from the previous request must be ignored
    clear_stats();
    push_host(11'h0AA);
    run_idle("stale_budget", 100);
    check_eq("stale_done", n_done, 1);
    check_eq("stale_lat", done_cyc - st_cyc[0], 4);

    // ready stuck high: three attempts then error
    clear_stats(); rmode = RM_HIGH; ready = 1'b1;
    push_host(11'h123);
    run_idle("tmo_budget", 200);
    check_eq("tmo_starts", n_start, 1 + MAX_RETRY);
    check_eq("tmo_gap1", st_cyc[1] - st_cyc[0], TIMEOUT + 1);
    check_eq("tmo_gap2", st_cyc[2] - st_cyc[1], TIMEOUT + 1);
    check_eq("tmo_err", n_err, 1);
    check_eq("tmo_eaddr", err_addr, 11'h123);
    check_eq("tmo_done", n_done, 0);

    // fill and backpressure with five requests
    clear_stats();
    for (int i = 1; i <= 5; i++) host_q.push_back(11'(i));
    drive_host();
    for (int i = 0; i < 20 && host_q.size() > 1; i++) tick();
    check_eq("fill_ready", req_ready, 1'b0);
    check_eq("fill_count", count, DEPTH);
    run_idle("fill_budget", 800);
    check_eq("fill_errs", n_err, 5);
    for (int i = 0; i < 5; i++) check_eq("fill_order", eaddr_log[i], 11'(i + 1));

    // acknowledge on the very last wait cycle of the final retry
    clear_stats(); rmode = RM_FINAL;
    push_host(11'h3C7);
    run_idle("final_budget", 200);
    check_eq("final_starts", n_start, 1 + MAX_RETRY);
    check_eq("final_done", n_done, 1);
    check_eq("final_err", n_err, 0);
    check_eq("final_lat", done_cyc - st_cyc[2], TIMEOUT + 1);

    // asynchronous reset in the middle of WAIT with three queued requests
    clear_stats(); rmode = RM_HIGH; ready = 1'b1;
    push_host(11'h011); push_host(11'h022); push_host(11'h033);
    for (int i = 0; i < 20 && n_start == 0; i++) tick();
    tick(); tick();
    check_eq("pre_rst_count", count, 3);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    host_q.delete();
    drive_host();
    compare_all();
    tick(); tick();
    reset = 1'b1;
    clear_stats();
    repeat (20) tick();
    check_eq("rst_starts", n_start, 0);
    check_eq("rst_done", n_done, 0);
    check_eq("rst_err", n_err, 0);

    // randomized traffic against the model
    rmode = RM_RAND;
    for (int i = 0; i < 1500; i++) begin
      if (host_q.size() < 3 && $urandom_range(0, 2) == 0) push_host(11'($urandom));
      tick();
    end
    run_idle("rand_budget", 600);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
